// File: rtl/riscv_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package riscv_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_WAIT_R = 1'b1
    } mem_state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 33;

    // Per-stage hold/bubble controls driven to the pipeline registers.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_mdu_seq.sv
// MUL/DIV launch sequencer: one start pulse per op, holds E until the
// result is ready, then waits in DONE until M is free to accept it.
module pipeline_ctrl_mdu_seq
    import riscv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic is_div,
    input  logic mem_stall,
    output logic start,
    output logic stall,
    output logic busy
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    mdu_state_e    state;
    logic [CW-1:0] cnt;

    // Outputs are forced low while reset is asserted so a held request
    // cannot leak a launch pulse during reset.
    assign start = rst_n & (state == MDU_IDLE) & req & !mem_stall;
    assign stall = rst_n & (((state == MDU_IDLE) & req) | (state == MDU_BUSY));
    assign busy  = (state != MDU_IDLE);

    // State and down-counter. BUSY lasts at least one cycle, so a
    // one-cycle op still passes through IDLE -> BUSY -> DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        state <= MDU_BUSY;
                        cnt   <= is_div ? DIV_INIT : MUL_INIT;
                    end
                end
                MDU_BUSY: begin
                    if (cnt <= ONE) state <= MDU_DONE;
                    if (cnt != '0)  cnt   <= cnt - ONE;
                end
                MDU_DONE: begin
                    if (!mem_stall) state <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges memory handshake, MDU, load-use
// and branch events into per-stage hold/bubble controls.
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lw_stall_i,
    input  logic             branch_taken_i,
    input  logic             mdu_req_i,
    input  logic             mdu_is_div_i,
    input  logic             dmem_req_i,
    input  logic             dmem_we_i,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    output logic             dmem_req_o,
    output logic             mdu_start_o,
    output logic             mdu_busy_o,
    output logic             stallF_o,
    output logic             stallD_o,
    output logic             stallE_o,
    output logic             stallM_o,
    output logic             flushD_o,
    output logic             flushE_o,
    output logic             flushM_o,
    output logic             flushW_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    mem_state_e  mem_state, mem_next;
    logic        mem_stall;
    logic        mdu_stall;
    stage_ctrl_t ctrl;

    // Memory handshake: a store finishes on grant, a load waits for rvalid.
    always_comb begin
        mem_next  = mem_state;
        mem_stall = 1'b0;
        case (mem_state)
            MEM_IDLE: begin
                if (dmem_req_i) begin
                    if (!dmem_gnt_i) begin
                        mem_stall = 1'b1;
                    end else if (!dmem_we_i) begin
                        mem_stall = 1'b1;
                        mem_next  = MEM_WAIT_R;
                    end
                end
            end
            MEM_WAIT_R: begin
                mem_stall = !dmem_rvalid_i;
                if (dmem_rvalid_i) mem_next = MEM_IDLE;
            end
            default: mem_next = MEM_IDLE;
        endcase
    end

    // Memory FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mem_state <= MEM_IDLE;
        else         mem_state <= mem_next;
    end

    // Request is only forwarded while no load response is outstanding.
    assign dmem_req_o = rst_ni & dmem_req_i & (mem_state == MEM_IDLE);

    pipeline_ctrl_mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .req       (mdu_req_i),
        .is_div    (mdu_is_div_i),
        .mem_stall (mem_stall),
        .start     (mdu_start_o),
        .stall     (mdu_stall),
        .busy      (mdu_busy_o)
    );

    // Priority mux. A branch is only flushed once E is free to advance;
    // it beats load-use so the redirect is never dropped.
    always_comb begin
        ctrl = '0;
        if (mem_stall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
            ctrl.flush_w = 1'b1;
        end else if (mdu_stall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.flush_m = 1'b1;
        end else if (branch_taken_i) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (lw_stall_i) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end
        if (!rst_ni) ctrl = '0;
    end

    assign stallF_o = ctrl.stall_f;
    assign stallD_o = ctrl.stall_d;
    assign stallE_o = ctrl.stall_e;
    assign stallM_o = ctrl.stall_m;
    assign flushD_o = ctrl.flush_d;
    assign flushE_o = ctrl.flush_e;
    assign flushM_o = ctrl.flush_m;
    assign flushW_o = ctrl.flush_w;

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_cnt_o <= '0;
        else if (ctrl.stall_f && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for the priority mux plus
// hand-built multi-cycle sequences (DIV, load wait, store wait, reset).
module tb_pipeline_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;
    localparam int CNT_W   = 6;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic lw, br, mreq, mdiv, dreq, we, gnt, rv;
    logic dmem_req_o, mdu_start_o, mdu_busy_o;
    logic stallF_o, stallD_o, stallE_o, stallM_o;
    logic flushD_o, flushE_o, flushM_o, flushW_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .lw_stall_i     (lw),
        .branch_taken_i (br),
        .mdu_req_i      (mreq),
        .mdu_is_div_i   (mdiv),
        .dmem_req_i     (dreq),
        .dmem_we_i      (we),
        .dmem_gnt_i     (gnt),
        .dmem_rvalid_i  (rv),
        .dmem_req_o     (dmem_req_o),
        .mdu_start_o    (mdu_start_o),
        .mdu_busy_o     (mdu_busy_o),
        .stallF_o       (stallF_o),
        .stallD_o       (stallD_o),
        .stallE_o       (stallE_o),
        .stallM_o       (stallM_o),
        .flushD_o       (flushD_o),
        .flushE_o       (flushE_o),
        .flushM_o       (flushM_o),
        .flushW_o       (flushW_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // {dmem_req, start, sF, sD, sE, sM, fD, fE, fM, fW}
    logic [9:0] outs;
    assign outs = {dmem_req_o, mdu_start_o, stallF_o, stallD_o, stallE_o, stallM_o,
                   flushD_o, flushE_o, flushM_o, flushW_o};

    localparam logic [9:0] O_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] O_LW    = 10'b00_1100_0100;
    localparam logic [9:0] O_BR    = 10'b00_0000_1100;
    localparam logic [9:0] O_MEMQ  = 10'b10_1111_0001; // mem stall, request visible
    localparam logic [9:0] O_MEMW  = 10'b00_1111_0001; // mem stall, waiting on rvalid
    localparam logic [9:0] O_REQ   = 10'b10_0000_0000;
    localparam logic [9:0] O_REQLW = 10'b10_1100_0100;
    localparam logic [9:0] O_REQBR = 10'b10_0000_1100;
    localparam logic [9:0] O_MDUS  = 10'b01_1110_0010; // launch cycle
    localparam logic [9:0] O_MDU   = 10'b00_1110_0010;

    typedef struct {
        string      name;
        logic       lw, br, mreq, dreq, we, gnt, rv;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic clr();
        lw = 0; br = 0; mreq = 0; mdiv = 0; dreq = 0; we = 0; gnt = 0; rv = 0;
    endtask

    task automatic do_reset();
        clr();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        //              name         lw br mq dq we gn rv  expected
        vecs[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 0, O_NONE};
        vecs[1]  = '{"lw",          1, 0, 0, 0, 0, 0, 0, O_LW};
        vecs[2]  = '{"br",          0, 1, 0, 0, 0, 0, 0, O_BR};
        vecs[3]  = '{"lw_br",       1, 1, 0, 0, 0, 0, 0, O_BR};
        vecs[4]  = '{"ld_nognt",    0, 0, 0, 1, 0, 0, 0, O_MEMQ};
        vecs[5]  = '{"st_gnt",      0, 0, 0, 1, 1, 1, 0, O_REQ};
        vecs[6]  = '{"mem_over_all",1, 1, 1, 1, 0, 0, 0, O_MEMQ};
        vecs[7]  = '{"st_gnt_lw",   1, 0, 0, 1, 1, 1, 0, O_REQLW};
        vecs[8]  = '{"rv_in_idle",  0, 0, 0, 0, 0, 0, 1, O_NONE};
        vecs[9]  = '{"st_gnt_br",   0, 1, 0, 1, 1, 1, 0, O_REQBR};
        vecs[10] = '{"ld_nognt_br", 0, 1, 0, 1, 0, 0, 0, O_MEMQ};

        // Reset with busy-looking inputs: everything must stay low.
        clr();
        rst_ni = 1'b0;
        lw = 1; br = 1; mreq = 1; dreq = 1;
        #12;
        sample();
        chk("rst_outs", outs, O_NONE);
        chk("rst_busy", mdu_busy_o, 0);
        chk("rst_cnt", stall_cnt_o, 0);
        clr();
        tick();
        rst_ni = 1'b1;

        // Table: combinational priority with both FSMs parked in IDLE.
        for (int i = 0; i < 11; i++) begin
            lw = vecs[i].lw; br = vecs[i].br; mreq = vecs[i].mreq;
            dreq = vecs[i].dreq; we = vecs[i].we; gnt = vecs[i].gnt; rv = vecs[i].rv;
            sample();
            chk(vecs[i].name, outs, vecs[i].exp);
            chk({vecs[i].name, "_busy"}, mdu_busy_o, 0);
            tick();
        end
        clr();
        sample();
        chk("table_cnt", stall_cnt_o, 5);

        // DIV alone: one start, 33 stall cycles, released in DONE.
        do_reset();
        begin
            int starts, se_hi, fm_hi;
            starts = 0; se_hi = 0; fm_hi = 0;
            mreq = 1; mdiv = 1;
            for (int c = 0; c < 34; c++) begin
                sample();
                starts += int'(mdu_start_o);
                se_hi  += int'(stallE_o);
                fm_hi  += int'(flushM_o);
                if (c == 0)  chk("div_start_c0", mdu_start_o, 1);
                if (c == 1)  chk("div_busy_c1", mdu_busy_o, 1);
                if (c == 33) chk("div_done_outs", outs, O_NONE);
                if (c == 33) chk("div_done_busy", mdu_busy_o, 1);
                tick();
            end
            mreq = 0; mdiv = 0;
            sample();
            chk("div_starts", starts, 1);
            chk("div_stallE", se_hi, 33);
            chk("div_flushM", fm_hi, 33);
            chk("div_cnt", stall_cnt_o, 33);
            chk("div_idle", mdu_busy_o, 0);
        end

        // Load: gnt in cycle 0, rvalid in cycle 3.
        do_reset();
        dreq = 1; we = 0;
        for (int c = 0; c < 4; c++) begin
            gnt = (c == 0);
            rv  = (c == 3);
            sample();
            chk($sformatf("ld_c%0d", c), outs, (c == 0) ? O_MEMQ : (c == 3) ? O_NONE : O_MEMW);
            tick();
        end
        clr();

        // Store with grant two cycles late; must not enter the read wait.
        do_reset();
        dreq = 1; we = 1;
        for (int c = 0; c < 4; c++) begin
            gnt = (c == 2);
            if (c == 3) begin dreq = 0; we = 0; gnt = 0; end
            sample();
            chk($sformatf("st_c%0d", c), outs, (c < 2) ? O_MEMQ : (c == 2) ? O_REQ : O_NONE);
            tick();
        end

        // MUL in E while a load waits: launch deferred until rvalid.
        do_reset();
        mreq = 1; mdiv = 0; dreq = 1; we = 0;
        for (int c = 0; c < 8; c++) begin
            logic [9:0] e;
            gnt = (c == 0);
            rv  = (c == 3);
            if (c == 4) dreq = 0;
            case (c)
                0:       e = O_MEMQ;
                1, 2:    e = O_MEMW;
                3:       e = O_MDUS;
                7:       e = O_NONE;
                default: e = O_MDU;
            endcase
            sample();
            chk($sformatf("mulmem_c%0d", c), outs, e);
            if (c == 7) chk("mulmem_done_busy", mdu_busy_o, 1);
            tick();
        end
        clr();

        // Branch held in E behind a MUL: flush only in the DONE cycle.
        do_reset();
        mreq = 1; br = 1;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk($sformatf("mulbr_c%0d", c), outs, (c == 0) ? O_MDUS : (c == 4) ? O_BR : O_MDU);
            tick();
        end
        clr();

        // Reset mid-DIV (counter at 20), request held; relaunch on release.
        do_reset();
        mreq = 1; mdiv = 1;
        for (int c = 0; c < 13; c++) tick();
        rst_ni = 1'b0;
        sample();
        chk("rstdiv_outs", outs, O_NONE);
        chk("rstdiv_busy", mdu_busy_o, 0);
        tick();
        sample();
        chk("rstdiv_edge_outs", outs, O_NONE);
        chk("rstdiv_cnt", stall_cnt_o, 0);
        tick();
        rst_ni = 1'b1;
        sample();
        chk("rstdiv_relaunch", outs, O_MDUS);
        chk("rstdiv_rel_busy", mdu_busy_o, 0);
        tick();
        sample();
        chk("rstdiv_after", mdu_start_o, 0);
        chk("rstdiv_after_busy", mdu_busy_o, 1);
        clr();

        // Stall counter saturates at all-ones.
        do_reset();
        lw = 1;
        for (int c = 0; c < 73; c++) begin
            sample();
            if (c == 62) chk("sat_62", stall_cnt_o, 62);
            if (c == 63) chk("sat_63", stall_cnt_o, 63);
            if (c == 72) chk("sat_hold", stall_cnt_o, 63);
            tick();
        end
        clr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
